oam_dma_arbiter: RTL and testbench

Sequences OAM DMA transfers and shares the external memory bus between the SM83 core and the DMA engine. A CPU write to 0xFF46 starts a LEN-byte copy from {page,00h} into OAM, one byte per slot. While the copy runs, the block owns the external bus and blocks CPU accesses outside HRAM. It sits between the SM83Core bus pins (A, D, RD, WR) and the memory/MMIO decode.

---
 rtl/oam_dma_arbiter.sv | 153 +++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// OAM DMA sequencer and external bus arbiter between the SM83 core and memory.
// A CPU write to FF46h starts a LEN-byte copy from {page,00h} into OAM.
// Optional build macro: DMA_REG_READBACK_EN (FF46h reads return the latched page).
module oam_dma_arbiter #(
  parameter int unsigned LEN         = 160,
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        CLK,
  input  logic        SYNC_RESET,
  input  logic [15:0] CPU_A,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_DOUT,
  output logic [7:0]  CPU_DIN,
  output logic [15:0] EXT_A,
  output logic        EXT_RD,
  output logic        EXT_WR,
  output logic [7:0]  EXT_DOUT,
  input  logic [7:0]  EXT_DIN,
  output logic [7:0]  OAM_A,
  output logic [7:0]  OAM_D,
  output logic        OAM_WR,
  output logic        DMA_ACTIVE
);

  localparam int unsigned IW        = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned START_CYC = START_DELAY * SLOT_CYCLES;
  localparam int unsigned CNT_MAX   = (START_CYC > SLOT_CYCLES) ? START_CYC : SLOT_CYCLES;
  localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    page_q, page_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] phase_q, phase_d;

  logic       rd_eff, wr_eff;
  logic       ff46_hit, ff46_wr;
  logic       hram_acc, in_xfer, dma_hold, slot_end;
  logic [7:0] srcpage;

  // Decode the CPU cycle; a simultaneous RD+WR is treated as a write.
  always_comb begin
    rd_eff   = CPU_RD & ~CPU_WR;
    wr_eff   = CPU_WR;
    ff46_hit = (CPU_A == 16'hFF46);
    ff46_wr  = wr_eff & ff46_hit;
    hram_acc = (rd_eff | wr_eff) & (CPU_A >= 16'hFF80) & (CPU_A <= 16'hFFFE);
    in_xfer  = (state_q == XFER);
    dma_hold = in_xfer & hram_acc;
    slot_end = in_xfer & (phase_q == SLOT_LAST) & ~dma_hold & ~ff46_wr;
    srcpage  = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;
  end

  // Next-state logic: an FF46h write restarts from any state and beats the slot-end write.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    if (ff46_wr) begin
      page_d  = CPU_DOUT;
      idx_d   = '0;
      phase_d = '0;
      state_d = (START_CYC == 0) ? XFER : START;
    end else begin
      unique case (state_q)
        IDLE: ;
        START: begin
          if (phase_q == START_LAST) begin
            phase_d = '0;
            state_d = XFER;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        XFER: begin
          if (!dma_hold) begin
            if (phase_q == SLOT_LAST) begin
              phase_d = '0;
              if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                state_d = IDLE;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus arbitration and OAM write strobe; outputs follow the current state combinationally.
  always_comb begin
    EXT_A      = CPU_A;
    EXT_RD     = rd_eff;
    EXT_WR     = wr_eff & ~ff46_wr;
    EXT_DOUT   = CPU_DOUT;
    CPU_DIN    = EXT_DIN;
    OAM_A      = '0;
    OAM_D      = '0;
    OAM_WR     = 1'b0;
    DMA_ACTIVE = 1'b0;
    if (in_xfer) begin
      DMA_ACTIVE = 1'b1;
      OAM_A      = 8'(idx_q);
      OAM_D      = EXT_DIN;
      OAM_WR     = slot_end & ~SYNC_RESET;
      if (!dma_hold) begin
        EXT_A   = {srcpage, 8'(idx_q)};
        EXT_RD  = 1'b1;
        EXT_WR  = 1'b0;
        CPU_DIN = 8'hFF;
      end
    end
`ifdef DMA_REG_READBACK_EN
    if (rd_eff && ff46_hit) begin
      CPU_DIN = page_q;
      if (!in_xfer) EXT_RD = 1'b0;
    end
`endif
  end

  // State registers with synchronous reset; reset aborts any transfer in flight.
  always_ff @(posedge CLK) begin
    if (SYNC_RESET) begin
      state_q <= IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: directed scenarios with random CPU
// traffic, checked against a progress-count reference model.
module tb_oam_dma_arbiter;

  localparam int unsigned LEN  = 160;
  localparam int unsigned SLOT = 4;
  localparam int unsigned SC   = 4;  // START_DELAY * SLOT
`ifdef DMA_REG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sync_reset;
  logic [15:0] cpu_a;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_dout, cpu_din;
  logic [15:0] ext_a;
  logic        ext_rd, ext_wr;
  logic [7:0]  ext_dout, ext_din;
  logic [7:0]  oam_a, oam_d;
  logic        oam_wr, dma_active;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  assign ext_din = mem(ext_a);

  oam_dma_arbiter #(.LEN(LEN), .SLOT_CYCLES(SLOT), .START_DELAY(1)) dut (
    .CLK(clk), .SYNC_RESET(sync_reset),
    .CPU_A(cpu_a), .CPU_RD(cpu_rd), .CPU_WR(cpu_wr), .CPU_DOUT(cpu_dout), .CPU_DIN(cpu_din),
    .EXT_A(ext_a), .EXT_RD(ext_rd), .EXT_WR(ext_wr), .EXT_DOUT(ext_dout), .EXT_DIN(ext_din),
    .OAM_A(oam_a), .OAM_D(oam_d), .OAM_WR(oam_wr), .DMA_ACTIVE(dma_active)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one progress counter of non-held cycles since the FF46h write.
  bit          m_act;
  int unsigned m_prog;
  logic [7:0]  m_page;

  int dut_pulses, exp_pulses, act_cycles, first_wr, last_wr, cyc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    dut_pulses = 0; exp_pulses = 0; act_cycles = 0; first_wr = -1; last_wr = -1;
  endtask

  // Drive one CLK of CPU activity, check outputs mid-cycle, then advance the model.
  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [7:0] d);
    logic rde, in_x, ff46w, hram, e_rd, e_wr, e_owr;
    logic [15:0] e_a, dma_a;
    logic [7:0]  e_din, src;
    int unsigned k, ph;
    sync_reset = rst; cpu_rd = rd; cpu_wr = wr; cpu_a = a; cpu_dout = d;
    #4;
    rde   = rd & ~wr;
    in_x  = m_act && (m_prog >= SC);
    ff46w = wr && (a == 16'hFF46);
    hram  = (rd | wr) && (a >= 16'hFF80) && (a <= 16'hFFFE);
    k     = in_x ? (m_prog - SC) / SLOT : 0;
    ph    = in_x ? (m_prog - SC) % SLOT : 0;
    src   = (m_page >= 8'hE0) ? m_page - 8'h20 : m_page;
    dma_a = {src, 8'(k)};
    e_owr = 1'b0;
    if (in_x && !hram) begin
      e_a = dma_a; e_rd = 1'b1; e_wr = 1'b0;
      e_din = (RB && a == 16'hFF46) ? m_page : 8'hFF;
      e_owr = !rst && !ff46w && (ph == SLOT - 1);
    end else if (in_x) begin
      e_a = a; e_rd = rde; e_wr = wr; e_din = mem(a);
    end else begin
      e_a = a; e_rd = rde && !(RB && a == 16'hFF46); e_wr = wr && !ff46w;
      e_din = (RB && a == 16'hFF46) ? m_page : mem(a);
    end
    chk("dma_active", {15'd0, dma_active}, {15'd0, in_x});
    chk("ext_a", ext_a, e_a);
    chk("ext_rd", {15'd0, ext_rd}, {15'd0, e_rd});
    chk("ext_wr", {15'd0, ext_wr}, {15'd0, e_wr});
    chk("ext_dout", {8'd0, ext_dout}, {8'd0, d});
    chk("oam_wr", {15'd0, oam_wr}, {15'd0, e_owr});
    if (rde) chk("cpu_din", {8'd0, cpu_din}, {8'd0, e_din});
    if (e_owr) begin
      exp_pulses++;
      chk("oam_a", {8'd0, oam_a}, {8'd0, 8'(k)});
      chk("oam_d", {8'd0, oam_d}, {8'd0, mem(dma_a)});
    end
    if (oam_wr === 1'b1) begin
      dut_pulses++;
      last_wr = cyc;
      if (first_wr < 0) first_wr = cyc;
    end
    if (dma_active === 1'b1) act_cycles++;
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_prog = 0; m_page = 8'h00;
    end else if (ff46w) begin
      m_act = 1; m_prog = 0; m_page = d;
    end else if (m_act && !(in_x && hram)) begin
      m_prog++;
      if (m_prog == SC + LEN * SLOT) m_act = 0;
    end
    if (ff46w) cyc = 0; else cyc++;
    #1;
  endtask

  task automatic rnd_cpu(output logic rd, output logic wr, output logic [15:0] a, output logic [7:0] d);
    int unsigned r;
    r = $urandom_range(0, 9);
    a = 16'($urandom); d = 8'($urandom); rd = 1'b0; wr = 1'b0;
    if (a == 16'hFF46) a = 16'h8000;
    case (r)
      4: begin rd = 1'b1; wr = 1'b1; a = 16'hFF80 + 16'($urandom_range(0, 126)); end
      5, 6: rd = 1'b1;
      7: begin rd = 1'b1; a = 16'hFF80 + 16'($urandom_range(0, 126)); end
      8: begin wr = 1'b1; a = 16'hFF80 + 16'($urandom_range(0, 126)); end
      9: wr = 1'b1;
      default: ;
    endcase
  endtask

  task automatic run_done(input bit traffic);
    logic rd, wr; logic [15:0] a; logic [7:0] d;
    int n = 0;
    while (m_act && n < 3000) begin
      if (traffic) rnd_cpu(rd, wr, a, d);
      else begin rd = 1'b0; wr = 1'b0; a = 16'h0000; d = 8'h00; end
      step(1'b0, rd, wr, a, d);
      n++;
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic advance_to(input int unsigned prog);
    int n = 0;
    while (m_act && m_prog != prog && n < 3000) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      n++;
    end
  endtask

  initial begin
    logic [7:0] pages [4];
    pages[0] = 8'hE2; pages[1] = 8'hFF; pages[2] = 8'hDF; pages[3] = 8'hE0;
    cyc = 0;
    m_act = 0; m_prog = 0; m_page = 8'h00;
    clear_counts();
    sync_reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 16'h1234; cpu_dout = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dma_active", {15'd0, dma_active}, 16'd0);
    chk("rst_oam_wr", {15'd0, oam_wr}, 16'd0);
    chk("rst_oam_a", {8'd0, oam_a}, 16'd0);
    chk("rst_oam_d", {8'd0, oam_d}, 16'd0);
    chk("rst_ext_rd", {15'd0, ext_rd}, 16'd0);
    chk("rst_ext_wr", {15'd0, ext_wr}, 16'd0);
    chk("rst_ext_a", ext_a, 16'h1234);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00);

    // Full quiet transfer from page C1h with timing landmarks.
    clear_counts();
    step(1'b0, 1'b0, 1'b1, 16'hFF46, 8'hC1);
    run_done(1'b0);
    chk("c1_pulses", 16'(dut_pulses), 16'd160);
    chk("c1_first_wr", 16'(first_wr), 16'd7);
    chk("c1_last_wr", 16'(last_wr), 16'd643);
    chk("c1_active_cycles", 16'(act_cycles), 16'd640);

    // Echo-mapping boundaries with random CPU traffic.
    foreach (pages[i]) begin
      clear_counts();
      step(1'b0, 1'b0, 1'b1, 16'hFF46, pages[i]);
      run_done(1'b1);
      chk("rand_pulses", 16'(dut_pulses), 16'd160);
      chk("rand_pulses_model", 16'(dut_pulses), 16'(exp_pulses));
    end

    // Blocked read at 8000h, then HRAM write delaying the next OAM write by one CLK.
    clear_counts();
    step(1'b0, 1'b0, 1'b1, 16'hFF46, 8'h40);
    advance_to(SC + 10 * SLOT + 1);
    step(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);
    step(1'b0, 1'b0, 1'b1, 16'hFF90, 8'h5A);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("hram_delay_wr", 16'(last_wr), 16'd48);
    run_done(1'b0);

    // Restart landing on the final phase of idx 50.
    clear_counts();
    step(1'b0, 1'b0, 1'b1, 16'hFF46, 8'hC3);
    advance_to(SC + 50 * SLOT + SLOT - 1);
    step(1'b0, 1'b0, 1'b1, 16'hFF46, 8'hD0);
    run_done(1'b0);
    chk("restart_pulses", 16'(dut_pulses), 16'd210);

    // Reset during idx 80 aborts the transfer.
    clear_counts();
    step(1'b0, 1'b0, 1'b1, 16'hFF46, 8'h55);
    advance_to(SC + 80 * SLOT + 1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (700) step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("reset_abort_pulses", 16'(dut_pulses), 16'd80);

    // FF46h read during XFER.
    clear_counts();
    step(1'b0, 1'b0, 1'b1, 16'hFF46, 8'h9A);
    step(1'b0, 1'b1, 1'b0, 16'hFF46, 8'h00);
    advance_to(SC + 2);
    step(1'b0, 1'b1, 1'b0, 16'hFF46, 8'h00);
    chk("ff46_read_xfer", {8'd0, cpu_din}, RB ? 16'h009A : 16'h00FF);
    run_done(1'b0);
    step(1'b0, 1'b1, 1'b0, 16'hFF46, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
